spi_slave_regs: RTL and testbench
=================================

Name: spi_slave_regs

Overview:
- Synthesizable FPGA SPI slave, Mode 0, MSB first, sitting directly downstream of the ESP32 SPI master; consumes cs/sclk/mosi and drives miso.
- Oversamples the SPI lines on sysclk (125 MHz), decodes COMMAND, ADDRESS and PAYLOAD fields, and writes into or reads from a small brightness register file.
- Register file contents are exported to the LED/PWM logic.

Parameters:
- CMD_BITS, 8, command field width
- ADDR_BITS, 8, address field width
- PAYLOAD_BITS, 8, payload / brightness register width
- REG_COUNT, 4, number of brightness registers (valid addresses 0..REG_COUNT-1)
- CMD_WRITE, 8'h02, write command code
- CMD_READ, 8'h03, read command code

Ports:
- sysclk  in  1  system clock, 125 MHz
- rst  in  1  synchronous reset, active-high
- cs  in  1  chip select, active low, asynchronous to sysclk
- sclk  in  1  SPI clock from master, asynchronous
- mosi  in  1  serial data from master, asynchronous
- miso  out  1  serial data to master
- wr_valid  out  1  one-cycle pulse when a register write is committed
- wr_addr  out  ADDR_BITS  address of the last committed write
- wr_data  out  PAYLOAD_BITS  data of the last committed write
- frame_err  out  1  one-cycle pulse on an aborted, unknown-command or out-of-range frame
- o_regs  out  REG_COUNT*PAYLOAD_BITS  flattened register file; reg i occupies bits [i*PAYLOAD_BITS +: PAYLOAD_BITS]

Behaviour:
- Clocking and reset: one clock (sysclk); reset is synchronous and active-high.
- Reset values: miso=0, wr_valid=0, wr_addr=0, wr_data=0, frame_err=0, o_regs=0, FSM=IDLE, counters and shift registers 0.
- Synchronizers: cs, sclk and mosi each pass through 2-FF synchronizers.
  - cs synchronizer resets to 0. A frame already in progress at reset therefore produces no cs falling edge and is ignored until cs goes high and then low again.
  - sclk and mosi synchronizers reset to 0.
- Edge detection:
  - sclk_rise = synchronized sclk 0->1. mosi is sampled (synchronized value) on sclk_rise.
  - sclk_fall = synchronized sclk 1->0. miso shifts on sclk_fall.
  - A 1-sysclk-wide sclk pulse is a valid edge pair.
- FSM states: IDLE, COMMAND, ADDRESS, PAYLOAD, DONE.
  - IDLE: on synchronized cs falling edge -> COMMAND; bit counter cleared.
  - COMMAND: shift in CMD_BITS bits on sclk_rise; after the last bit, latch cmd -> ADDRESS.
  - ADDRESS: shift in ADDR_BITS bits. On the cycle the last address bit is sampled:
    - latch addr;
    - if cmd==CMD_READ and addr<REG_COUNT, load the tx shift register with reg[addr], otherwise with 0;
    - miso = tx MSB on the next cycle;
    - -> PAYLOAD.
  - PAYLOAD: shift in PAYLOAD_BITS bits; for reads, miso advances one bit on each sclk_fall. After the last bit:
    - write: if cmd==CMD_WRITE and addr<REG_COUNT, then the next cycle updates reg[addr], wr_addr and wr_data and pulses wr_valid;
    - error: if the command is unknown or addr>=REG_COUNT, pulse frame_err on that cycle and make no write;
    - -> DONE.
  - DONE: ignore further sclk edges; miso=0; on synchronized cs high -> IDLE.
- Abort: synchronized cs rising while in COMMAND, ADDRESS or PAYLOAD -> IDLE next cycle, frame_err pulse, no write, miso=0.
- Write latency: wr_valid is asserted exactly 1 sysclk after the sclk_rise of the final payload bit, as detected after synchronization.
- miso is 0 whenever not in a valid read PAYLOAD phase.
- Reset mid-frame: all state cleared; the remainder of the frame is ignored as described above.
- Back-to-back frames: a new cs falling edge is accepted in the cycle after IDLE is re-entered.
- Simultaneous events: cs rising in the same cycle as the final payload sclk_rise is treated as an abort, so no write occurs.

Test Plan:
- Write frame 0x02/0x01/0xA5 (SCLK = sysclk/5 pulses) -> one wr_valid pulse, wr_addr=0x01, wr_data=0xA5, o_regs[15:8]=0xA5, other regs 0.
- Preload reg2=0x3C, then read frame 0x03/0x02/xx -> miso bits 0,0,1,1,1,1,0,0 sampled at the 8 payload rising edges; no wr_valid.
- Write to addr 0x07 (>=REG_COUNT) -> frame_err pulse, o_regs unchanged; a read of addr 0x07 returns miso all 0.
- cs deasserted after 12 bits of a write -> frame_err pulse, no wr_valid, FSM back in IDLE; the following complete write 0x02/0x00/0x11 succeeds.
- Assert rst mid-payload with cs held low -> outputs zero; extra sclk edges are ignored until cs is raised and lowered; the next frame decodes correctly.
- Unknown command 0x55 followed by extra sclk pulses after the payload -> single frame_err, DONE holds until cs high, no writes.

Source files
------------

// File: rtl/spi_slave_regs.sv
// SPI Mode 0 slave (MSB first) oversampled on sysclk, decoding command/address/payload
// frames into writes and reads of a small brightness register file.
module spi_slave_regs #(
  parameter int CMD_BITS     = 8,
  parameter int ADDR_BITS    = 8,
  parameter int PAYLOAD_BITS = 8,
  parameter int REG_COUNT    = 4,
  parameter logic [CMD_BITS-1:0] CMD_WRITE = 8'h02,
  parameter logic [CMD_BITS-1:0] CMD_READ  = 8'h03
) (
  input  logic                              sysclk,
  input  logic                              rst,
  input  logic                              cs,
  input  logic                              sclk,
  input  logic                              mosi,
  output logic                              miso,
  output logic                              wr_valid,
  output logic [ADDR_BITS-1:0]              wr_addr,
  output logic [PAYLOAD_BITS-1:0]           wr_data,
  output logic                              frame_err,
  output logic [REG_COUNT*PAYLOAD_BITS-1:0] o_regs
);

  localparam int MAX_AP     = (ADDR_BITS > PAYLOAD_BITS) ? ADDR_BITS : PAYLOAD_BITS;
  localparam int SHIFT_BITS = (CMD_BITS > MAX_AP) ? CMD_BITS : MAX_AP;
  localparam int CNT_W      = $clog2(SHIFT_BITS + 1);
  localparam int IDX_W      = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_BITS - 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_BITS - 1);
  localparam logic [CNT_W-1:0] PAY_LAST  = CNT_W'(PAYLOAD_BITS - 1);

  typedef enum logic [2:0] {IDLE, COMMAND, ADDRESS, PAYLOAD, DONE} state_t;

  logic [1:0] cs_sync_reg, sclk_sync_reg, mosi_sync_reg;
  logic       cs_prev_reg, sclk_prev_reg;
  logic       cs_s, sclk_s, mosi_s, cs_fall, cs_rise, sclk_rise, sclk_fall;

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        bit_cnt_reg, bit_cnt_next;
  logic [SHIFT_BITS-1:0]   shift_reg, shift_next, shift_in;
  logic [CMD_BITS-1:0]     cmd_reg, cmd_next;
  logic [ADDR_BITS-1:0]    addr_reg, addr_next, addr_in;
  logic [PAYLOAD_BITS-1:0] tx_reg, tx_next, rd_word;
  logic                    miso_reg, miso_next;
  logic                    wr_valid_reg, wr_valid_next;
  logic                    frame_err_reg, frame_err_next;
  logic [ADDR_BITS-1:0]    wr_addr_reg, wr_addr_next;
  logic [PAYLOAD_BITS-1:0] wr_data_reg, wr_data_next;
  logic                    reg_we;
  logic                    addr_in_ok, addr_ok;
  logic [PAYLOAD_BITS-1:0] regs_reg [REG_COUNT];

  assign cs_s      = cs_sync_reg[1];
  assign sclk_s    = sclk_sync_reg[1];
  assign mosi_s    = mosi_sync_reg[1];
  assign cs_fall   = cs_prev_reg & ~cs_s;
  assign cs_rise   = ~cs_prev_reg & cs_s;
  assign sclk_rise = ~sclk_prev_reg & sclk_s;
  assign sclk_fall = sclk_prev_reg & ~sclk_s;

  assign shift_in   = {shift_reg[SHIFT_BITS-2:0], mosi_s};
  assign addr_in    = shift_in[ADDR_BITS-1:0];
  assign addr_in_ok = (32'(addr_in) < 32'(REG_COUNT));
  assign addr_ok    = (32'(addr_reg) < 32'(REG_COUNT));
  assign rd_word    = regs_reg[addr_in[IDX_W-1:0]];

  always_ff @(posedge sysclk) begin
    if (rst) begin
      cs_sync_reg   <= '0;
      sclk_sync_reg <= '0;
      mosi_sync_reg <= '0;
      cs_prev_reg   <= 1'b0;
      sclk_prev_reg <= 1'b0;
      state_reg     <= IDLE;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      cmd_reg       <= '0;
      addr_reg      <= '0;
      tx_reg        <= '0;
      miso_reg      <= 1'b0;
      wr_valid_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= '0;
    end else begin
      cs_sync_reg   <= {cs_sync_reg[0], cs};
      sclk_sync_reg <= {sclk_sync_reg[0], sclk};
      mosi_sync_reg <= {mosi_sync_reg[0], mosi};
      cs_prev_reg   <= cs_s;
      sclk_prev_reg <= sclk_s;
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      shift_reg     <= shift_next;
      cmd_reg       <= cmd_next;
      addr_reg      <= addr_next;
      tx_reg        <= tx_next;
      miso_reg      <= miso_next;
      wr_valid_reg  <= wr_valid_next;
      frame_err_reg <= frame_err_next;
      wr_addr_reg   <= wr_addr_next;
      wr_data_reg   <= wr_data_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    shift_next     = shift_reg;
    cmd_next       = cmd_reg;
    addr_next      = addr_reg;
    tx_next        = tx_reg;
    miso_next      = miso_reg;
    wr_valid_next  = 1'b0;
    wr_addr_next   = wr_addr_reg;
    wr_data_next   = wr_data_reg;
    frame_err_next = 1'b0;
    reg_we         = 1'b0;
    case (state_reg)
      IDLE: begin
        miso_next = 1'b0;
        if (cs_fall) begin
          state_next   = COMMAND;
          bit_cnt_next = '0;
        end
      end
      COMMAND, ADDRESS, PAYLOAD: begin
        if (cs_rise) begin
          // cs rising beats a coincident sclk edge, so a late abort never writes
          state_next     = IDLE;
          frame_err_next = 1'b1;
          miso_next      = 1'b0;
          tx_next        = '0;
        end else if (sclk_rise) begin
          shift_next   = shift_in;
          bit_cnt_next = bit_cnt_reg + 1'b1;
          if (state_reg == COMMAND && bit_cnt_reg == CMD_LAST) begin
            cmd_next     = shift_in[CMD_BITS-1:0];
            bit_cnt_next = '0;
            state_next   = ADDRESS;
          end else if (state_reg == ADDRESS && bit_cnt_reg == ADDR_LAST) begin
            addr_next    = addr_in;
            bit_cnt_next = '0;
            state_next   = PAYLOAD;
            tx_next      = (cmd_reg == CMD_READ && addr_in_ok) ? rd_word : '0;
            miso_next    = tx_next[PAYLOAD_BITS-1];
          end else if (state_reg == PAYLOAD && bit_cnt_reg == PAY_LAST) begin
            state_next = DONE;
            miso_next  = 1'b0;
            tx_next    = '0;
            if (cmd_reg == CMD_WRITE && addr_ok) begin
              reg_we        = 1'b1;
              wr_valid_next = 1'b1;
              wr_addr_next  = addr_reg;
              wr_data_next  = shift_in[PAYLOAD_BITS-1:0];
            end else if (cmd_reg != CMD_READ || !addr_ok) begin
              frame_err_next = 1'b1;
            end
          end
        end else if (sclk_fall && state_reg == PAYLOAD && bit_cnt_reg != '0) begin
          // MSB is already on miso from the address phase; advance only after a payload bit
          tx_next   = tx_reg << 1;
          miso_next = tx_reg[PAYLOAD_BITS-2];
        end
      end
      DONE: begin
        miso_next = 1'b0;
        if (cs_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < REG_COUNT; gi++) begin : g_regs
      always_ff @(posedge sysclk) begin
        if (rst) begin
          regs_reg[gi] <= '0;
        end else if (reg_we && addr_reg[IDX_W-1:0] == IDX_W'(gi)) begin
          regs_reg[gi] <= shift_in[PAYLOAD_BITS-1:0];
        end
      end
      assign o_regs[gi*PAYLOAD_BITS +: PAYLOAD_BITS] = regs_reg[gi];
    end
  endgenerate

  assign miso      = miso_reg;
  assign wr_valid  = wr_valid_reg;
  assign wr_addr   = wr_addr_reg;
  assign wr_data   = wr_data_reg;
  assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_spi_slave_regs.sv
// Directed bench for spi_slave_regs: an SPI master model drives frames, a scoreboard
// holds expected writes and miso bits, and a monitor pops them as the DUT responds.
module tb_spi_slave_regs;

  logic        sysclk = 1'b0;
  logic        rst, cs, sclk, mosi;
  logic        miso, wr_valid, frame_err;
  logic [7:0]  wr_addr, wr_data;
  logic [31:0] o_regs;

  int          tests = 0;
  int          fails = 0;
  int          wr_seen = 0;
  int          err_seen = 0;
  longint      last_rise_t = 0;
  logic [15:0] exp_wr[$];
  logic        exp_miso[$];
  logic [7:0]  model_regs[4];

  always #4 sysclk = ~sysclk;

  spi_slave_regs dut (
    .sysclk    (sysclk),
    .rst       (rst),
    .cs        (cs),
    .sclk      (sclk),
    .mosi      (mosi),
    .miso      (miso),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .frame_err (frame_err),
    .o_regs    (o_regs)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_flat();
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = model_regs[i];
    return r;
  endfunction

  // Monitor: every committed write must match the oldest expected one
  always @(negedge sysclk) begin
    if (!rst) begin
      if (wr_valid) begin
        logic [15:0] e;
        wr_seen++;
        check("wr_latency", 32'(($time - last_rise_t) / 8), 32'd3);
        check("wr_queue", 32'(exp_wr.size()), 32'd1);
        if (exp_wr.size() != 0) begin
          e = exp_wr.pop_front();
          check("wr_addr", 32'(wr_addr), 32'(e[15:8]));
          check("wr_data", 32'(wr_data), 32'(e[7:0]));
          check("wr_reg", 32'(o_regs[e[9:8]*8 +: 8]), 32'(e[7:0]));
        end
      end
      if (frame_err) err_seen++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  // One SCLK period of 5 sysclks: low 3 (miso sampled just before the rise), high 2
  task automatic spi_bit(input logic b, input bit chk_payload);
    logic m;
    logic e;
    mosi = b;
    tick(3);
    m = miso;
    if (chk_payload) begin
      if (exp_miso.size() != 0) begin
        e = exp_miso.pop_front();
        check("miso_bit", 32'(m), 32'(e));
      end
    end else begin
      check("miso_idle", 32'(m), 32'd0);
    end
    sclk = 1'b1;
    last_rise_t = $time;
    tick(2);
    sclk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v, input bit chk);
    for (int i = 7; i >= 0; i--) spi_bit(v[i], chk);
  endtask

  task automatic frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d, input bit rd);
    cs = 1'b0;
    tick(4);
    send_byte(c, 1'b0);
    send_byte(a, 1'b0);
    send_byte(d, rd);
    tick(4);
    cs = 1'b1;
    tick(4);
  endtask

  task automatic expect_write(input logic [7:0] a, input logic [7:0] d);
    exp_wr.push_back({a, d});
    model_regs[a[1:0]] = d;
  endtask

  task automatic expect_read(input logic [7:0] a);
    logic [7:0] v;
    v = (a < 8'd4) ? model_regs[a[1:0]] : 8'h00;
    for (int i = 7; i >= 0; i--) exp_miso.push_back(v[i]);
  endtask

  task automatic verify(input string tag, input int e0, input int w0, input int de, input int dw);
    check({tag, "_frame_err"}, 32'(err_seen - e0), 32'(de));
    check({tag, "_wr_count"}, 32'(wr_seen - w0), 32'(dw));
    check({tag, "_o_regs"}, o_regs, model_flat());
    $display("[TB] %s: frame_err=%0d writes=%0d o_regs=0x%08h", tag, err_seen - e0, wr_seen - w0, o_regs);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, w0;
    rst = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
    for (int i = 0; i < 4; i++) model_regs[i] = 8'h00;
    tick(3);
    check("rst_miso", 32'(miso), 32'd0);
    check("rst_wr_valid", 32'(wr_valid), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_o_regs", o_regs, 32'd0);
    rst = 1'b0;
    tick(4);

    e0 = err_seen; w0 = wr_seen;
    expect_write(8'h01, 8'hA5);
    frame(8'h02, 8'h01, 8'hA5, 1'b0);
    verify("write_a5", e0, w0, 0, 1);

    e0 = err_seen; w0 = wr_seen;
    expect_write(8'h02, 8'h3C);
    frame(8'h02, 8'h02, 8'h3C, 1'b0);
    verify("preload_3c", e0, w0, 0, 1);

    e0 = err_seen; w0 = wr_seen;
    expect_read(8'h02);
    frame(8'h03, 8'h02, 8'h00, 1'b1);
    verify("read_reg2", e0, w0, 0, 0);

    e0 = err_seen; w0 = wr_seen;
    frame(8'h02, 8'h07, 8'hEE, 1'b0);
    verify("write_oor", e0, w0, 1, 0);

    e0 = err_seen; w0 = wr_seen;
    expect_read(8'h07);
    frame(8'h03, 8'h07, 8'h00, 1'b1);
    verify("read_oor", e0, w0, 1, 0);

    // Abort after 12 bits, then a full write must still decode
    e0 = err_seen; w0 = wr_seen;
    cs = 1'b0;
    tick(4);
    send_byte(8'h02, 1'b0);
    for (int i = 0; i < 4; i++) spi_bit(1'b0, 1'b0);
    tick(2);
    cs = 1'b1;
    tick(6);
    verify("abort12", e0, w0, 1, 0);

    e0 = err_seen; w0 = wr_seen;
    expect_write(8'h00, 8'h11);
    frame(8'h02, 8'h00, 8'h11, 1'b0);
    verify("after_abort", e0, w0, 0, 1);

    // Reset in the middle of a payload with cs held low
    cs = 1'b0;
    tick(4);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    for (int i = 7; i >= 4; i--) spi_bit(1'(8'h5A >> i), 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) model_regs[i] = 8'h00;
    tick(2);
    check("midrst_o_regs", o_regs, 32'd0);
    check("midrst_wr_addr", 32'(wr_addr), 32'd0);
    check("midrst_wr_data", 32'(wr_data), 32'd0);
    check("midrst_miso", 32'(miso), 32'd0);
    rst = 1'b0;
    tick(2);
    e0 = err_seen; w0 = wr_seen;
    for (int i = 3; i >= 0; i--) spi_bit(1'(8'h5A >> i), 1'b0);
    send_byte(8'hFF, 1'b0);
    tick(4);
    cs = 1'b1;
    tick(4);
    verify("midrst_ignored", e0, w0, 0, 0);

    e0 = err_seen; w0 = wr_seen;
    expect_write(8'h03, 8'h5A);
    frame(8'h02, 8'h03, 8'h5A, 1'b0);
    verify("after_rst", e0, w0, 0, 1);

    // Unknown command, then extra pulses while DONE waits for cs high
    e0 = err_seen; w0 = wr_seen;
    cs = 1'b0;
    tick(4);
    send_byte(8'h55, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'hAA, 1'b0);
    tick(4);
    cs = 1'b1;
    tick(4);
    verify("unknown_cmd", e0, w0, 1, 0);

    check("end_wr_queue", 32'(exp_wr.size()), 32'd0);
    check("end_miso_queue", 32'(exp_miso.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
